equiv_check_ctrl: RTL and testbench
===================================

EQUIV_CHECK_CTRL -- requirements
Module: equiv_check_ctrl

Interface
REQ-001 The block SHALL have parameter PIPE_LAT, default 1: cycles from stimulus drive to the matching y_1/y_2 sample (legal range 1..8).
REQ-002 The block SHALL have parameter RST_CYC, default 2: cycles dut_rst is held high before the first vector.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: pulse that begins a run; ignored while busy.
REQ-006 The block SHALL have port num_vectors, input, 16 bits: vectors per run, sampled on start.
REQ-007 The block SHALL have port seed, input, 64 bits: LFSR seed, sampled on start.
REQ-008 The block SHALL have stimulus outputs wire0 (18 bits), wire1 (14 bits, signed), wire2 (10 bits, signed) and wire3 (21 bits, signed), all fanned to both DUT copies.
REQ-009 The block SHALL have port dut_rst, output, 1 bit: reset to both DUT copies.
REQ-010 The block SHALL have inputs y_1 and y_2, 91 bits each: the outputs of the two DUT copies.
REQ-011 The block SHALL have outputs busy (1 bit), done (1 bit), pass (1 bit), mismatch_count (16 bits) and first_fail_idx (16 bits).

Function
REQ-012 The FSM SHALL have states IDLE, DUT_RST, RUN, DRAIN and DONE.
REQ-013 In IDLE or DONE, start SHALL sample num_vectors/seed, clear the counters and pass/done, and go to DUT_RST.
REQ-014 DUT_RST SHALL drive dut_rst=1 for exactly RST_CYC cycles, then go to RUN; if num_vectors==0 it SHALL go to DRAIN instead.
REQ-015 RUN SHALL issue one vector per cycle, stepping the LFSR once per vector, and go to DRAIN after vector index num_vectors-1 is issued.
REQ-016 DRAIN SHALL last PIPE_LAT cycles, then go to DONE.
REQ-017 DONE SHALL hold done=1 and pass=(mismatch_count==0) until the next start or rst.
REQ-018 busy SHALL be 1 in DUT_RST, RUN and DRAIN, and 0 otherwise.
REQ-019 The LFSR SHALL be a 64-bit Galois LFSR with polynomial x^64+x^63+x^61+x^60+1; a zero seed SHALL be replaced by 64'h1.
REQ-020 Stimulus slicing SHALL be wire0=lfsr[17:0], wire1=lfsr[31:18], wire2=lfsr[41:32], wire3=lfsr[62:42], registered outputs.
REQ-021 Stimulus outputs SHALL hold their last value outside RUN.
REQ-022 A PIPE_LAT-deep valid/index shift register SHALL tag each issued vector; when the tagged valid emerges, y_1 SHALL be compared with y_2.
REQ-023 Compares SHALL occur only for tagged vectors; y values during DUT_RST or IDLE are don't-care.
REQ-024 On a mismatch, mismatch_count SHALL increment, saturating at 16'hFFFF.
REQ-025 On the first mismatch of a run, first_fail_idx SHALL capture the vector index; later mismatches SHALL NOT overwrite it.
REQ-026 A start pulse in DUT_RST, RUN or DRAIN SHALL have no effect.

Reset
REQ-027 rst SHALL force IDLE from any state, including mid-run.
REQ-028 During and after rst, outputs SHALL be: busy=0, done=0, pass=0, dut_rst=1, mismatch_count=0, first_fail_idx=0, all wireN=0.
REQ-029 The LFSR and the tag pipeline SHALL be cleared by rst.
REQ-030 dut_rst SHALL remain 1 in IDLE.

Configuration
REQ-031 With EQUIV_CHECK_STOP_ON_FAIL_EN defined, the first mismatch SHALL abort issuing, go to DRAIN, and then DONE with pass=0; vectors still in flight are compared and counted.
REQ-032 Without EQUIV_CHECK_STOP_ON_FAIL_EN, all num_vectors vectors SHALL be issued regardless of mismatches.

Structure
REQ-033 Package equiv_check_pkg SHALL hold the FSM state enum, the width constants (Y_W=91, STIM_W=63, per-wire widths), the LFSR polynomial constant and the NULL_SEED constant.
REQ-034 Sub-module equiv_lfsr64 SHALL implement the LFSR with ports load, seed, step and state.
REQ-035 The compare logic and FSM SHALL stay in equiv_check_ctrl.

Verification
REQ-036 Identical DUTs, num_vectors=100, seed=64'h1, PIPE_LAT=1 -> done after 2+100+1 cycles, pass=1, mismatch_count=0.
REQ-037 y_2 forced to y_1^1 for vector indices 5 and 9 only -> mismatch_count=2, first_fail_idx=5, pass=0 (with STOP_ON_FAIL_EN: mismatch_count=1, DONE reached early).
REQ-038 num_vectors=0 -> DUT_RST 2 cycles, then DRAIN, then DONE with pass=1 and wireN unchanged.
REQ-039 seed=0 -> first issued wire0 equals lfsr(64'h1 stepped once)[17:0], identical to a run with seed=1.
REQ-040 rst asserted at vector 50 of 100 -> next cycle IDLE, busy=0, counters 0, dut_rst=1; a new start runs cleanly.
REQ-041 Always-mismatching DUTs, num_vectors=16'hFFFF, macro undefined -> mismatch_count saturates at 16'hFFFF, first_fail_idx=0.

Source files
------------

// File: rtl/equiv_check_pkg.sv
// equiv_check_pkg
// Shared types and constants for the equivalence-check sequencer:
//   state_t     - sequencer FSM states
//   Y_W         - width of each DUT copy output
//   STIM_W      - total stimulus width (wire0..wire3 concatenated)
//   Wn_W/Wn_LSB - per-wire width and LFSR slice position
//   LFSR_POLY   - Galois mask for x^64+x^63+x^61+x^60+1 (right-shifting)
//   NULL_SEED   - value substituted for an all-zero seed
package equiv_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DUT_RST = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int Y_W    = 91;
  localparam int STIM_W = 63;
  localparam int CNT_W  = 16;

  localparam int W0_W   = 18;
  localparam int W1_W   = 14;
  localparam int W2_W   = 10;
  localparam int W3_W   = 21;
  localparam int W0_LSB = 0;
  localparam int W1_LSB = 18;
  localparam int W2_LSB = 32;
  localparam int W3_LSB = 42;

  localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;
  localparam logic [63:0] NULL_SEED = 64'h1;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? LFSR_POLY : 64'h0);
  endfunction

endpackage

// File: rtl/equiv_lfsr64.sv
// equiv_lfsr64
// 64-bit Galois LFSR stimulus source.
//   clk, rst : clock, synchronous active-high reset (state cleared to 0)
//   load     : capture seed (zero seed replaced by NULL_SEED)
//   seed     : 64-bit seed
//   step     : advance one position
//   state    : current LFSR value
// The state is kept one step ahead: after load it already holds seed stepped
// once, so the controller can register a vector straight from it while
// stepping in the same cycle.
module equiv_lfsr64
  import equiv_check_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= lfsr_next((seed == 64'h0) ? NULL_SEED : seed);
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/equiv_check_ctrl.sv
// equiv_check_ctrl
// Drives pseudo-random stimulus into two DUT copies and compares their
// outputs, reporting mismatch count and the first failing vector index.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a run (ignored while busy)
//   num_vectors     : vectors per run, sampled on start
//   seed            : LFSR seed, sampled on start
//   wire0..wire3    : registered stimulus to both DUT copies
//   dut_rst         : reset to both DUT copies
//   y_1, y_2        : DUT copy outputs
//   busy/done/pass  : run status
//   mismatch_count  : saturating mismatch count
//   first_fail_idx  : vector index of the first mismatch
// Optional: EQUIV_CHECK_STOP_ON_FAIL_EN aborts issuing on the first mismatch.
//
// state     | meaning
// S_IDLE    | waiting for start, DUTs held in reset
// S_DUT_RST | DUTs in reset for RST_CYC cycles
// S_RUN     | one vector issued per cycle
// S_DRAIN   | PIPE_LAT cycles for in-flight vectors to be compared
// S_DONE    | results valid until next start
module equiv_check_ctrl
  import equiv_check_pkg::*;
#(
  parameter int PIPE_LAT = 1,
  parameter int RST_CYC  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vectors,
  input  logic [63:0]            seed,
  output logic [W0_W-1:0]        wire0,
  output logic signed [W1_W-1:0] wire1,
  output logic signed [W2_W-1:0] wire2,
  output logic signed [W3_W-1:0] wire3,
  output logic                   dut_rst,
  input  logic [Y_W-1:0]         y_1,
  input  logic [Y_W-1:0]         y_2,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       mismatch_count,
  output logic [CNT_W-1:0]       first_fail_idx
);

  localparam int LAST = PIPE_LAT - 1;
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, nv_q, idx_q;
  logic [63:0]       lfsr_state;
  logic              start_ok, issue, cmp_fail, abort;
  logic [PIPE_LAT-1:0] tag_v;
  logic [CNT_W-1:0]  tag_idx [PIPE_LAT];
  logic              unused_msb;

  assign unused_msb = lfsr_state[63];
  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cmp_fail   = tag_v[LAST] && (y_1 != y_2);

`ifdef EQUIV_CHECK_STOP_ON_FAIL_EN
  assign abort = cmp_fail;
`else
  assign abort = 1'b0;
`endif

  assign issue = (state_q == S_RUN) && !abort;

  equiv_lfsr64 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .seed  (seed),
    .step  (issue),
    .state (lfsr_state)
  );

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    pass    = 1'b0;
    dut_rst = 1'b0;
    case (state_q)
      S_IDLE: begin
        dut_rst = 1'b1;
        if (start) state_d = S_DUT_RST;
      end
      S_DUT_RST: begin
        busy    = 1'b1;
        dut_rst = 1'b1;
        if (cnt_q == '0) state_d = (nv_q == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort || (idx_q == nv_q - 1'b1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (mismatch_count == '0);
        if (start) state_d = S_DUT_RST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      nv_q           <= '0;
      idx_q          <= '0;
      wire0          <= '0;
      wire1          <= '0;
      wire2          <= '0;
      wire3          <= '0;
      tag_v          <= '0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_idx[i] <= '0;
    end else begin
      state_q <= state_d;

      // Down-counter reloaded on entry to each timed state.
      if (state_d != state_q) begin
        if (state_d == S_DUT_RST)    cnt_q <= RST_LOAD;
        else if (state_d == S_DRAIN) cnt_q <= DRAIN_LOAD;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (issue) begin
        wire0 <= lfsr_state[W0_LSB +: W0_W];
        wire1 <= $signed(lfsr_state[W1_LSB +: W1_W]);
        wire2 <= $signed(lfsr_state[W2_LSB +: W2_W]);
        wire3 <= $signed(lfsr_state[W3_LSB +: W3_W]);
        idx_q <= idx_q + 1'b1;
      end

      tag_v[0]   <= issue;
      tag_idx[0] <= idx_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end

      if (start_ok) begin
        nv_q           <= num_vectors;
        idx_q          <= '0;
        mismatch_count <= '0;
        first_fail_idx <= '0;
      end else if (cmp_fail) begin
        if (mismatch_count != '1) mismatch_count <= mismatch_count + 1'b1;
        if (mismatch_count == '0) first_fail_idx <= tag_idx[LAST];
      end
    end
  end

endmodule

// File: tb/tb_equiv_check_ctrl.sv
module tb_equiv_check_ctrl;

  logic               clk = 1'b0;
  logic               rst, start;
  logic [15:0]        num_vectors;
  logic [63:0]        seed;
  logic [17:0]        wire0;
  logic signed [13:0] wire1;
  logic signed [9:0]  wire2;
  logic signed [20:0] wire3;
  logic               dut_rst, busy, done, pass;
  logic [90:0]        y_1, y_2;
  logic [15:0]        mismatch_count, first_fail_idx;

  int          checks = 0;
  int          passed = 0;
  int          mode = 0;  // 0 identical, 1 corrupt vectors 5 and 9, 2 always differ
  logic [62:0] v5, v9, stim;

  always #5 clk = ~clk;

  assign stim = {wire3, wire2, wire1, wire0};
  assign y_1  = {28'd0, stim};
  assign y_2  = (mode == 2) ? ~y_1 :
                ((mode == 1) && ((stim == v5) || (stim == v9))) ? (y_1 ^ 91'd1) : y_1;

  equiv_check_ctrl #(.PIPE_LAT(1), .RST_CYC(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_vectors    (num_vectors),
    .seed           (seed),
    .wire0          (wire0),
    .wire1          (wire1),
    .wire2          (wire2),
    .wire3          (wire3),
    .dut_rst        (dut_rst),
    .y_1            (y_1),
    .y_2            (y_2),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .first_fail_idx (first_fail_idx)
  );

  function automatic logic [63:0] step64(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'd0);
  endfunction

  // Stimulus of vector k: seed (zero -> 1) stepped k+1 times, bits 62:0.
  function automatic logic [62:0] vec_of(input logic [63:0] sd, input int k);
    logic [63:0] s;
    s = (sd == 64'd0) ? 64'd1 : sd;
    for (int i = 0; i <= k; i++) s = step64(s);
    return s[62:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] nv, input logic [63:0] sd);
    num_vectors = nv;
    seed        = sd;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL reset_pass got %0b want 0", pass); else passed++;
    checks++; if (dut_rst !== 1'b1) $display("FAIL reset_dut_rst got %0b want 1", dut_rst); else passed++;
    checks++; if (mismatch_count !== 16'd0) $display("FAIL reset_mc got %0d want 0", mismatch_count); else passed++;
    checks++; if (first_fail_idx !== 16'd0) $display("FAIL reset_ffi got %0d want 0", first_fail_idx); else passed++;
    checks++; if (stim !== 63'd0) $display("FAIL reset_wires got %h want 0", stim); else passed++;
    rst = 1'b0;
    tick();
    checks++; if (dut_rst !== 1'b1) $display("FAIL idle_dut_rst got %0b want 1", dut_rst); else passed++;
  endtask

  // 100 identical vectors; a second start mid-run must be ignored.
  task automatic test_basic();
    int n;
    logic [62:0] exp_v;
    mode = 0;
    do_start(16'd100, 64'd1);
    num_vectors = 16'd5;
    seed        = 64'd7;
    n = 0;
    while (!done && n < 400) begin
      if (n < 2) begin
        checks++; if (dut_rst !== 1'b1) $display("FAIL basic_dut_rst n=%0d got %0b want 1", n, dut_rst); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy n=%0d got %0b want 1", n, busy); else passed++;
      end
      if (n == 2) begin
        checks++; if (dut_rst !== 1'b0) $display("FAIL basic_run_dut_rst got %0b want 0", dut_rst); else passed++;
      end
      if (n >= 3 && n <= 102) begin
        exp_v = vec_of(64'd1, n - 3);
        checks++; if (stim !== exp_v) $display("FAIL basic_vec idx=%0d got %h want %h", n - 3, stim, exp_v); else passed++;
      end
      start = (n == 50);
      tick();
      n++;
    end
    start = 1'b0;
    checks++; if (n !== 103) $display("FAIL basic_latency got %0d want 103", n); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL basic_pass got %0b want 1", pass); else passed++;
    checks++; if (mismatch_count !== 16'd0) $display("FAIL basic_mc got %0d want 0", mismatch_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_done got %0b want 0", busy); else passed++;
  endtask

  task automatic test_zero_vectors();
    int n;
    logic [62:0] exp_v;
    exp_v = vec_of(64'd1, 99);
    do_start(16'd0, 64'd5);
    n = 0;
    while (!done && n < 50) begin
      if (n < 2) begin
        checks++; if (dut_rst !== 1'b1) $display("FAIL zero_dut_rst n=%0d got %0b want 1", n, dut_rst); else passed++;
      end
      if (n == 2) begin
        checks++; if ({busy, dut_rst} !== 2'b10) $display("FAIL zero_drain got busy,dut_rst=%b want 10", {busy, dut_rst}); else passed++;
      end
      tick();
      n++;
    end
    checks++; if (n !== 3) $display("FAIL zero_latency got %0d want 3", n); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL zero_pass got %0b want 1", pass); else passed++;
    checks++; if (stim !== exp_v) $display("FAIL zero_wires_hold got %h want %h", stim, exp_v); else passed++;
  endtask

  task automatic test_mismatch();
    int n;
    int exp_n;
    int exp_mc;
    v5 = vec_of(64'd1, 5);
    v9 = vec_of(64'd1, 9);
    mode = 1;
`ifdef EQUIV_CHECK_STOP_ON_FAIL_EN
    exp_n  = 10;
    exp_mc = 1;
`else
    exp_n  = 103;
    exp_mc = 2;
`endif
    do_start(16'd100, 64'd1);
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    checks++; if (n !== exp_n) $display("FAIL mm_latency got %0d want %0d", n, exp_n); else passed++;
    checks++; if (mismatch_count !== 16'(exp_mc)) $display("FAIL mm_count got %0d want %0d", mismatch_count, exp_mc); else passed++;
    checks++; if (first_fail_idx !== 16'd5) $display("FAIL mm_first_idx got %0d want 5", first_fail_idx); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL mm_pass got %0b want 0", pass); else passed++;
    mode = 0;
  endtask

  task automatic test_seed_zero();
    int n;
    logic [63:0] s1;
    logic [62:0] exp_v;
    s1    = step64(64'd1);
    exp_v = vec_of(64'd1, 0);
    do_start(16'd3, 64'd0);
    n = 0;
    while (!done && n < 50) begin
      if (n == 3) begin
        checks++; if (wire0 !== s1[17:0]) $display("FAIL seed0_wire0 got %h want %h", wire0, s1[17:0]); else passed++;
        checks++; if (stim !== exp_v) $display("FAIL seed0_vec got %h want %h", stim, exp_v); else passed++;
      end
      tick();
      n++;
    end
    checks++; if (n !== 6) $display("FAIL seed0_latency got %0d want 6", n); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL seed0_pass got %0b want 1", pass); else passed++;
  endtask

  task automatic test_rst_midrun();
    int n;
    logic [62:0] exp_v;
`ifdef EQUIV_CHECK_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 1;
`endif
    do_start(16'd100, 64'd1);
    for (int i = 0; i < 53; i++) tick();
    exp_v = vec_of(64'd1, 50);
    checks++; if (stim !== exp_v) $display("FAIL rst_mid_vec50 got %h want %h", stim, exp_v); else passed++;
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %0b want 0", busy); else passed++;
    checks++; if (dut_rst !== 1'b1) $display("FAIL rst_mid_dut_rst got %0b want 1", dut_rst); else passed++;
    checks++; if (mismatch_count !== 16'd0) $display("FAIL rst_mid_mc got %0d want 0", mismatch_count); else passed++;
    checks++; if (first_fail_idx !== 16'd0) $display("FAIL rst_mid_ffi got %0d want 0", first_fail_idx); else passed++;
    checks++; if (stim !== 63'd0) $display("FAIL rst_mid_wires got %h want 0", stim); else passed++;
    rst  = 1'b0;
    mode = 0;
    tick();
    exp_v = vec_of(64'd1, 0);
    do_start(16'd10, 64'd1);
    n = 0;
    while (!done && n < 100) begin
      if (n == 3) begin
        checks++; if (stim !== exp_v) $display("FAIL rerun_vec0 got %h want %h", stim, exp_v); else passed++;
      end
      tick();
      n++;
    end
    checks++; if (n !== 13) $display("FAIL rerun_latency got %0d want 13", n); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL rerun_pass got %0b want 1", pass); else passed++;
  endtask

`ifndef EQUIV_CHECK_STOP_ON_FAIL_EN
  task automatic test_saturate();
    int n;
    mode = 2;
    do_start(16'hFFFF, 64'd1);
    n = 0;
    while (!done && n < 70000) begin
      tick();
      n++;
    end
    checks++; if (n !== 65538) $display("FAIL sat_latency got %0d want 65538", n); else passed++;
    checks++; if (mismatch_count !== 16'hFFFF) $display("FAIL sat_mc got %h want ffff", mismatch_count); else passed++;
    checks++; if (first_fail_idx !== 16'd0) $display("FAIL sat_ffi got %0d want 0", first_fail_idx); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL sat_pass got %0b want 0", pass); else passed++;
    mode = 0;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_vectors = 16'd0;
    seed        = 64'd0;
    v5          = '1;
    v9          = '1;
    test_reset();
    test_basic();
    test_zero_vectors();
    test_mismatch();
    test_seed_zero();
    test_rst_midrun();
`ifndef EQUIV_CHECK_STOP_ON_FAIL_EN
    test_saturate();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
